// File: rtl/imm_decode_queue.sv
// Immediate-decode stage: classifies the immediate format of a 32-bit ARMv8 instruction,
// builds the 64-bit extended operand and holds results in a 2-entry FIFO. Macro: IMM_BTYPE_EN.
module imm_decode_queue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_imm,
    output logic [2:0]       out_kind,
    output logic [CNT_W-1:0] imm_cnt
);

    localparam logic [2:0] KIND_NONE  = 3'd0;
    localparam logic [2:0] KIND_ALU   = 3'd1;
    localparam logic [2:0] KIND_DT    = 3'd2;
    localparam logic [2:0] KIND_SHAMT = 3'd3;
    localparam logic [2:0] KIND_CB    = 3'd4;
    localparam logic [2:0] KIND_B     = 3'd5;

`ifdef IMM_BTYPE_EN
    localparam logic BTYPE_EN = 1'b1;
`else
    localparam logic BTYPE_EN = 1'b0;
`endif

    logic [2:0]  dec_kind;
    logic [63:0] dec_imm;

    logic [63:0] buf_imm  [2];
    logic [2:0]  buf_kind [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    // Opcode classes are checked in priority order; the first match wins.
    // NOTE: always_comb assigns defaults first so no path can infer a latch.
    always_comb begin
        dec_kind = KIND_NONE;
        dec_imm  = '0;
        if (in_instr[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100,
                                    10'b1111000100, 10'b1001001000, 10'b1011001000,
                                    10'b1101001000}) begin
            dec_kind = KIND_ALU;
            dec_imm  = {{52{in_instr[21]}}, in_instr[21:10]};
        end else if (in_instr[31:21] inside {11'b11111000010, 11'b11111000000}) begin
            dec_kind = KIND_DT;
            dec_imm  = {{55{in_instr[20]}}, in_instr[20:12]};
        end else if (in_instr[31:21] inside {11'b11010011011, 11'b11010011010}) begin
            dec_kind = KIND_SHAMT;
            dec_imm  = {58'd0, in_instr[15:10]};
        end else if (in_instr[31:24] inside {8'b10110100, 8'b10110101}) begin
            dec_kind = KIND_CB;
            dec_imm  = {{43{in_instr[23]}}, in_instr[23:5], 2'b00};
        end else if (BTYPE_EN && (in_instr[31:26] inside {6'b000101, 6'b100101})) begin
            dec_kind = KIND_B;
            dec_imm  = {{36{in_instr[25]}}, in_instr[25:0], 2'b00};
        end
    end

    // in_ready depends only on occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_imm   = out_valid ? buf_imm[rd_ptr]  : 64'd0;
    assign out_kind  = out_valid ? buf_kind[rd_ptr] : KIND_NONE;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; outputs are masked by occupancy so stale data never leaks.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            buf_imm[wr_ptr]  <= dec_imm;
            buf_kind[wr_ptr] <= dec_kind;
        end
    end

    // A pop in a flush cycle still counts: the consumer did take the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_cnt <= '0;
        end else if (pop && (out_kind != KIND_NONE) && (imm_cnt != {CNT_W{1'b1}})) begin
            imm_cnt <= imm_cnt + 1'b1;
        end
    end

endmodule

// File: doc/imm_decode_queue.md
# imm_decode_queue

Registered immediate-decode stage for the ARMv8 pipeline's ID side. It accepts 32-bit instructions over a valid/ready handshake, classifies the immediate format from the opcode, and produces the 64-bit extended operand. Results are held in a 2-entry buffer toward the ID/EX boundary, with flush and a saturating immediate-usage counter. It sequences immediate selection so downstream logic receives a ready-made operand and kind tag.

## Interface
- `CNT_W`, 16: width of the immediate-usage counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous flush of buffered entries (branch redirect).
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: block can accept an instruction this cycle.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes the head entry.
- `out_imm` out 64: extended immediate of the head entry.
- `out_kind` out 3: 0 NONE, 1 ALU_IMM, 2 DT, 3 SHAMT, 4 CB, 5 B; 6–7 are never produced.
- `imm_cnt` out CNT_W: count of dequeued entries with kind ≠ 0.

## Operation
- Decode is combinational on `in_instr`, written into the buffer on accept (`in_valid && in_ready`). Opcode match priority follows the list order:
  - ALU_IMM: bits[31:22] ∈ {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1011001000, 1101001000}. Imm = sign-extend(bits[21:10]).
  - DT: bits[31:21] ∈ {11111000010, 11111000000}. Imm = sign-extend(bits[20:12]).
  - SHAMT: bits[31:21] ∈ {11010011011, 11010011010}. Imm = zero-extend(bits[15:10]).
  - CB: bits[31:24] ∈ {10110100, 10110101}. Imm = sign-extend(bits[23:5]) << 2.
  - B: bits[31:26] ∈ {000101, 100101}. Imm = sign-extend(bits[25:0]) << 2. Present only with the macro; see Configuration.
  - Anything else: kind 0, imm 0.
- All shifts and extensions are done at 64 bits. Bits shifted out are discarded; no overflow flag.
- Buffer: 2-entry FIFO with read pointer, write pointer and a 0–2 occupancy count.
  - `in_ready` = occupancy < 2, driven from registered state only, with no combinational path from `out_ready`.
  - `out_valid` = occupancy > 0. `out_imm` and `out_kind` come from the head entry and are 0 when empty.
  - Push and pop in the same cycle leave occupancy unchanged and both pointers advance.
  - Pointers wrap modulo 2.
- `imm_cnt` increments on each pop (`out_valid && out_ready`) whose head kind ≠ 0. It saturates at all-ones and is cleared only by reset.
- `flush`:
  - Next edge sets occupancy to 0 and both pointers to 0.
  - Any push or pop in the flush cycle is discarded; a pop in that cycle still counts toward `imm_cnt`.
- Reset (asynchronous, any time, including mid-transfer):
  - Occupancy, pointers and `imm_cnt` go to 0.
  - `out_valid` = 0, `out_imm` = 0, `out_kind` = 0, `in_ready` = 1 while `rst_n` is low and after release.

## Timing
- Latency: an instruction accepted at edge N is visible on `out_*` after edge N (one cycle), provided the buffer was empty.
- There is no pass-through when empty: `out_valid` is never asserted in the same cycle as the accept.
- Full throughput: one accept and one pop per cycle sustained when `out_ready` = 1.
- Full (occupancy 2): `in_ready` = 0. A pop that cycle raises `in_ready` the following cycle.
- Handshake rule: the consumer may drop `out_ready` at any time; the head entry stays stable until popped or flushed.

## Configuration
- `IMM_BTYPE_EN` defined: B/BL (bits[31:26] = 000101 or 100101) decode as kind 5 with the 26-bit word offset described above.
- `IMM_BTYPE_EN` undefined: those opcodes decode as kind 0, imm 0, and do not increment `imm_cnt`.

## Test plan
- Reset, then push 0x913FFC41 (ADDI imm12 = 0xFFF) → after one cycle `out_valid` = 1, `out_kind` = 1, `out_imm` = 0xFFFFFFFFFFFFFFFF. Pop → `imm_cnt` = 1.
- Back-to-back pushes 0xF8500000 (LDUR addr9 = 0x100), 0xD360FC00 (LSL shamt 63), 0xB4FFFFE0 (CBZ imm19 = 0x7FFFF), with `out_ready` = 1 → in order:
  - kind 2, imm 0xFFFFFFFFFFFFFF00
  - kind 3, imm 0x000000000000003F
  - kind 4, imm 0xFFFFFFFFFFFFFFFC
- `out_ready` = 0, offer 3 instructions → `in_ready` falls after the 2nd accept and the 3rd is held. Raise `out_ready` → entries drain in order and the 3rd is accepted the cycle after the first pop.
- Fill 2 entries, assert `flush` together with `in_valid` → next cycle occupancy 0, `out_valid` = 0, flushed-cycle push lost.
- Push 0x14000001 → with `IMM_BTYPE_EN`: kind 5, imm 0x4. Without it: kind 0, imm 0, `imm_cnt` unchanged.
- Drop `rst_n` asynchronously mid-stream with 1 entry buffered and `imm_cnt` = 5 → immediately `out_valid` = 0, `imm_cnt` = 0, `in_ready` = 1.
